// File: rtl/instr_queue_if.sv
// Instruction queue bus: parser push side plus I2C-controller valid/ready head side.
// master = parser/controller environment, slave = the queue itself.
`timescale 1ns/1ps
interface instr_queue_if #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
);
  logic             push;
  logic [7:0]       addr_in;
  logic [7:0]       op_in;
  logic [15:0]      data_in;
  logic             buffers_full;
  logic             instr_valid;
  logic             instr_ready;
  logic [7:0]       addr_out;
  logic [7:0]       op_out;
  logic [15:0]      data_out;
  logic [PTR_W:0]   count;
  logic             overflow;

  modport master (
    output push, addr_in, op_in, data_in, instr_ready,
    input  buffers_full, instr_valid, addr_out, op_out, data_out, count, overflow
  );

  modport slave (
    input  push, addr_in, op_in, data_in, instr_ready,
    output buffers_full, instr_valid, addr_out, op_out, data_out, count, overflow
  );
endinterface

// File: rtl/instr_queue.sv
// Circular instruction FIFO between the UART parser and the I2C controller.
// Define INSTR_QUEUE_EARLY_FULL_EN to raise buffers_full one entry early.
`timescale 1ns/1ps
module instr_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  instr_queue_if.slave  bus
);

  typedef struct packed {
    logic [7:0]  addr;
    logic [7:0]  op;
    logic [15:0] data;
  } entry_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             overflow;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // count alone decides full/empty, so pointers can wrap freely.
  assign full    = (count == FULL_CNT);
  assign do_push = bus.push && !full;
  assign do_pop  = (count != '0) && bus.instr_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A push against a full queue is dropped even if a pop frees a slot.
      if (bus.push && full) overflow <= 1'b1;
    end
  end

  // NOTE: storage is reset on purpose so the head fields read zero after
  // reset; drop this reset only if that visible-zero guarantee is not needed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= '{addr: bus.addr_in, op: bus.op_in, data: bus.data_in};
    end
  end

  assign bus.instr_valid = (count != '0);
  assign bus.addr_out    = mem[rd_ptr].addr;
  assign bus.op_out      = mem[rd_ptr].op;
  assign bus.data_out    = mem[rd_ptr].data;
  assign bus.count       = count;
  assign bus.overflow    = overflow;

`ifdef INSTR_QUEUE_EARLY_FULL_EN
  // One slot held back for an instruction the parser is already receiving.
  assign bus.buffers_full = (count >= FULL_CNT - 1'b1);
`else
  assign bus.buffers_full = full;
`endif

endmodule

// File: tb/tb_instr_queue.sv
// Directed self-checking bench for instr_queue (DEPTH = 4).
// Also valid when built with INSTR_QUEUE_EARLY_FULL_EN defined.
`timescale 1ns/1ps
module tb_instr_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  instr_queue_if #(.DEPTH(DEPTH), .PTR_W(PTR_W)) bus ();

  instr_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_full(input int c);
`ifdef INSTR_QUEUE_EARLY_FULL_EN
    return c >= DEPTH - 1;
`else
    return c == DEPTH;
`endif
  endfunction

  // Advance one rising edge, then settle 1ns so outputs are sampled off the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [7:0] a, input logic [7:0] o, input logic [15:0] d,
                         input logic rdy);
    bus.push        = 1'b1;
    bus.addr_in     = a;
    bus.op_in       = o;
    bus.data_in     = d;
    bus.instr_ready = rdy;
    tick();
    bus.push        = 1'b0;
    bus.instr_ready = 1'b0;
  endtask

  task automatic do_pop();
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [7:0] a, input logic [7:0] o,
                            input logic [15:0] d);
    check({tag, "_valid"}, bus.instr_valid, 1'b1);
    check({tag, "_addr"},  bus.addr_out, a);
    check({tag, "_op"},    bus.op_out, o);
    check({tag, "_data"},  bus.data_out, d);
  endtask

  task automatic check_idle(input string tag, input logic exp_ovf);
    check({tag, "_count"}, bus.count, 0);
    check({tag, "_valid"}, bus.instr_valid, 1'b0);
    check({tag, "_full"},  bus.buffers_full, 1'b0);
    check({tag, "_ovf"},   bus.overflow, exp_ovf);
  endtask

  initial begin
    bus.push        = 1'b0;
    bus.addr_in     = '0;
    bus.op_in       = '0;
    bus.data_in     = '0;
    bus.instr_ready = 1'b0;

    // Power-on reset
    tick();
    check_idle("rst", 1'b0);
    check("rst_addr", bus.addr_out, 0);
    check("rst_op",   bus.op_out, 0);
    check("rst_data", bus.data_out, 0);
    tick();
    reset = 1'b1;
    tick();
    check_idle("post_rst", 1'b0);

    // Single entry held while not ready, then popped
    do_push(8'h01, 8'h08, 16'hBEEF, 1'b0);
    check("single_count", bus.count, 1);
    for (int i = 0; i < 5; i++) begin
      check_head("hold", 8'h01, 8'h08, 16'hBEEF);
      tick();
    end
    do_pop();
    check_idle("single_pop", 1'b0);

    // Fill to DEPTH, then push while full with a simultaneous pop
    for (int i = 0; i < DEPTH; i++) begin
      do_push(8'h10 + 8'(i), 8'(i), 16'hA000 + 16'(i), 1'b0);
      check("fill_count", bus.count, i + 1);
      check("fill_full",  bus.buffers_full, exp_full(i + 1));
      check_head("fill_head", 8'h10, 8'h00, 16'hA000);
    end
    check("fill_ovf", bus.overflow, 1'b0);
    do_push(8'h14, 8'h04, 16'hA004, 1'b1);
    check("drop_ovf",   bus.overflow, 1'b1);
    check("drop_count", bus.count, 3);
    check("drop_full",  bus.buffers_full, exp_full(3));
    for (int i = 1; i < DEPTH; i++) begin
      check_head("drain", 8'h10 + 8'(i), 8'(i), 16'hA000 + 16'(i));
      do_pop();
    end
    check_idle("drained", 1'b1);

    // Pointer wrap: push/pop pairs, occupancy never above 1
    for (int i = 0; i < 10; i++) begin
      do_push(8'h20 + 8'(i), 8'h50 + 8'(i), 16'h1000 + 16'(i), 1'b0);
      check("wrap_count1", bus.count, 1);
      check_head("wrap", 8'h20 + 8'(i), 8'h50 + 8'(i), 16'h1000 + 16'(i));
      do_pop();
      check("wrap_count0", bus.count, 0);
    end

    // Simultaneous push and pop at count = 2
    do_push(8'h30, 8'h60, 16'h3030, 1'b0);
    do_push(8'h31, 8'h61, 16'h3131, 1'b0);
    check("sim_pre_count", bus.count, 2);
    do_push(8'h32, 8'h62, 16'h3232, 1'b1);
    check("sim_count", bus.count, 2);
    check_head("sim_head", 8'h31, 8'h61, 16'h3131);
    do_pop();
    check_head("sim_tail", 8'h32, 8'h62, 16'h3232);
    do_pop();
    check_idle("sim_done", 1'b1);

    // Asynchronous reset mid-stream, between clock edges
    for (int i = 0; i < 3; i++) do_push(8'h40 + 8'(i), 8'h70, 16'h4444, 1'b0);
    check("mid_count", bus.count, 3);
    #2 reset = 1'b0;
    #1;
    check_idle("async_rst", 1'b0);
    check("async_addr", bus.addr_out, 0);
    check("async_op",   bus.op_out, 0);
    check("async_data", bus.data_out, 0);
    reset = 1'b1;
    tick();
    check_idle("async_rel", 1'b0);
    check("async_rel_addr", bus.addr_out, 0);

    // Fourth push into DEPTH-1 entries is always accepted
    for (int i = 0; i < DEPTH - 1; i++) do_push(8'h50 + 8'(i), 8'h00, 16'h5555, 1'b0);
    check("early_full", bus.buffers_full, exp_full(DEPTH - 1));
    do_push(8'h53, 8'h00, 16'h5555, 1'b0);
    check("last_count", bus.count, DEPTH);
    check("last_ovf",   bus.overflow, 1'b0);
    check("last_full",  bus.buffers_full, 1'b1);
    check_head("last_head", 8'h50, 8'h00, 16'h5555);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
